stream_mux_n: RTL and testbench
===============================

Name: stream_mux_n

Overview:
- Registered N-channel, W-bit stream multiplexer with valid/ready handshake on every input and on the output.
- Successor to the plain 2:1 combinational selector: generalised in data width and channel count.
- Adds two selection modes (external select or round-robin arbitration), a one-stage output register with backpressure, and a transfer counter.
- Sits between several producer streams and a single consumer, such as a UART TX or display path.

Parameters:
DW, 8, data width per channel in bits (>=1)
NCH, 4, number of input channels (2..16)
SELW, 2, select/channel-index width; must equal ceil(log2(NCH))
CNTW, 16, width of the transfer counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = external select, 1 = round-robin arbitration
sel  input  SELW  channel chosen in mode 0
in_valid  input  NCH  per-channel data valid, bit i = channel i
in_data  input  NCH*DW  packed data; channel i occupies bits [i*DW +: DW]
in_ready  output  NCH  per-channel accept, bit i = channel i
out_valid  output  1  output register holds valid data
out_data  output  DW  registered selected data
out_ch  output  SELW  index of the channel that produced out_data
out_ready  input  1  consumer accepts out_data this cycle
xfer_cnt  output  CNTW  count of completed input transfers

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_ch=0, xfer_cnt=0.
  - Round-robin pointer ptr=NCH-1, so channel 0 has first priority after reset.
  - in_ready is all-zero while rst_n is low.
- load = !out_valid || out_ready (combinational). The output register may take new data this cycle.
- Grant logic (combinational, evaluated every cycle):
  - mode 0: candidate = sel. gnt_vld = (sel < NCH) && in_valid[sel]. An out-of-range sel gives no grant, ever.
  - mode 1: search channels ptr+1, ptr+2, ... wrapping modulo NCH, ending at ptr. The first channel with in_valid=1 is granted. gnt_vld = |in_valid.
- in_ready[i] = load && gnt_vld && (gnt == i). At most one bit is set per cycle. in_ready may depend combinationally on in_valid, out_ready, mode and sel.
- Input transfer on channel i = in_valid[i] && in_ready[i] at a rising edge. On transfer:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
  - xfer_cnt <= xfer_cnt+1, wrapping from 2^CNTW-1 to 0.
  - In mode 1 only, ptr <= i. In mode 0, ptr is unchanged.
- load=1 with no grant: out_valid <= 0. out_data and out_ch hold their last values.
- load=0 (out_valid=1, out_ready=0): all registers hold. in_ready=0 on every channel.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of one transfer per cycle when out_ready is held high.
- Simultaneous output consume and input transfer in the same cycle: the register is replaced; no bubble and no loss.
- Changing mode or sel while out_valid=1 does not alter the held output. The change affects only the next grant.
- Switching from mode 0 to mode 1 resumes round-robin from the stored ptr.
- Reset asserted mid-transfer: the held word is discarded and no in_ready is issued. After reset deassertion, operation restarts with channel 0 as highest round-robin priority.
- Producers must hold in_data and in_valid stable until accepted. The block does not check this.

Test Plan:
- Reset, mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=A5, out_ch=2, xfer_cnt=1.
- mode=1, all four channels valid continuously (data 8'h10, 8'h11, 8'h12, 8'h13), out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles; xfer_cnt=6 after 6 transfers.
- mode=1, out_ready held low for 3 cycles after the first word -> out_data stable; in_ready=0000 for those 3 cycles; on release, next grant goes to ptr+1, not back to channel 0.
- mode=0, NCH=3 build (SELW=2), sel=3 with all valid -> in_ready=000 indefinitely; once the held word is consumed, out_valid=0 and xfer_cnt does not change.
- CNTW=4 build, 17 transfers -> xfer_cnt reads 15 after 15 transfers, 0 after 16, 1 after 17.
- rst_n pulsed low asynchronously (between clock edges) while out_valid=1, out_ready=0 -> out_valid and xfer_cnt go to 0 immediately without a clock edge; the first grant after release is channel 0 in mode 1.

Source files
------------

// File: rtl/stream_mux_n.sv
// stream_mux_n: registered N-channel valid/ready stream mux with external-select or round-robin grant.
// One output register with backpressure; xfer_cnt counts accepted input words.
module stream_mux_n #(
  parameter int DW   = 8,
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [NCH-1:0]      in_valid,
  input  logic [NCH*DW-1:0]   in_data,
  output logic [NCH-1:0]      in_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_ready,
  output logic [CNTW-1:0]     xfer_cnt
);
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] xfer_cnt_q, xfer_cnt_d;
  logic            load, xfer, gnt_vld, sel_hit, rr_vld;
  logic [SELW-1:0] gnt, rr_gnt;
  logic [DW-1:0]   gnt_data;
  always_comb begin
    sel_hit  = 1'b0;
    rr_vld   = 1'b0;
    rr_gnt   = '0;
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) if (int'(sel) == i) sel_hit = in_valid[i];
    // round-robin: scan distances 1..NCH from ptr, first valid channel wins
    for (int k = 1; k <= NCH; k++)
      for (int i = 0; i < NCH; i++)
        if (!rr_vld && in_valid[i] && i == (int'(ptr_q) + k) % NCH) begin
          rr_vld = 1'b1;
          rr_gnt = SELW'(i);
        end
    gnt     = mode ? rr_gnt : sel;
    gnt_vld = mode ? rr_vld : sel_hit;
    for (int i = 0; i < NCH; i++) if (int'(gnt) == i) gnt_data = in_data[i*DW +: DW];
  end
  assign load     = !out_valid_q || out_ready;
  assign xfer     = load && gnt_vld;
  assign in_ready = (rst_n && xfer) ? NCH'(1) << gnt : '0;
  always_comb begin
    out_valid_d = load ? gnt_vld : out_valid_q;
    out_data_d  = xfer ? gnt_data : out_data_q;
    out_ch_d    = xfer ? gnt : out_ch_q;
    ptr_d       = (xfer && mode) ? gnt : ptr_q;
    xfer_cnt_d  = xfer ? xfer_cnt_q + 1'b1 : xfer_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: directed + random checks of stream_mux_n against a cycle-level reference model.
// A second 3-channel, 4-bit-counter instance covers out-of-range select and counter wrap.
module tb_stream_mux_n;
  logic clk = 1'b0;
  logic rst_n, mode, out_ready, out_valid;
  logic [1:0] sel, out_ch;
  logic [3:0] in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0] out_data;
  logic [15:0] xfer_cnt;
  logic mode3, ordy3, ov3;
  logic [1:0] sel3, oc3;
  logic [2:0] iv3, rdy3;
  logic [23:0] id3;
  logic [7:0] od3;
  logic [3:0] cnt3;
  int checks = 0, errors = 0;
  bit m_valid;
  logic [7:0] m_data;
  int m_ch, m_cnt, m_ptr;

  always #5 clk = ~clk;

  stream_mux_n #(.DW(8), .NCH(4), .SELW(2), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt));

  stream_mux_n #(.DW(8), .NCH(3), .SELW(2), .CNTW(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(iv3), .in_data(id3),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_ch(oc3),
    .out_ready(ordy3), .xfer_cnt(cnt3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 8'h00; m_ch = 0; m_cnt = 0; m_ptr = 3;
  endtask

  // called at posedge+1 with inputs already driven; checks in_ready, then the registered result
  task automatic cyc();
    bit gv, ld;
    int g, c;
    logic [3:0] er;
    ld = !m_valid || out_ready;
    gv = 0;
    g = 0;
    if (!mode) begin
      g = int'(sel);
      gv = bit'(in_valid >> g);
    end else begin
      for (int d = 1; d <= 4; d++) begin
        c = (m_ptr + d) % 4;
        if (!gv && bit'(in_valid >> c)) begin gv = 1; g = c; end
      end
    end
    er = (ld && gv) ? 4'(1 << g) : 4'b0;
    #2;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk); #1;
    if (ld) begin
      if (gv) begin
        m_valid = 1;
        m_data = 8'(in_data >> (8 * g));
        m_ch = g;
        m_cnt = (m_cnt + 1) % 65536;
        if (mode) m_ptr = g;
      end else m_valid = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), m_ch);
    chk("xfer_cnt", 32'(xfer_cnt), m_cnt);
  endtask

  initial begin
    rst_n = 0; mode = 0; sel = 2'd0; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1;
    mode3 = 0; sel3 = 2'd0; iv3 = 3'b000; id3 = 24'hC2B1A0; ordy3 = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    in_valid = 4'h0;
    rst_n = 1;
    @(posedge clk); #1;
    // external select of channel 2
    mode = 0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000;
    cyc();
    chk("sel2_data", 32'(out_data), 32'hA5);
    chk("sel2_cnt", 32'(xfer_cnt), 1);
    // round-robin with all channels valid, starting from channel 0
    mode = 1; in_valid = 4'hF; in_data = 32'h13121110;
    repeat (6) cyc();
    chk("rr_last_ch", 32'(out_ch), 1);
    chk("rr_cnt", 32'(xfer_cnt), 7);
    // backpressure: hold for 3 cycles, then resume at ptr+1
    out_ready = 0;
    repeat (3) cyc();
    chk("hold_data", 32'(out_data), 32'h11);
    out_ready = 1;
    cyc();
    chk("resume_ch", 32'(out_ch), 2);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom % 4) != 0;
      cyc();
    end
    // asynchronous reset while a word is held under backpressure
    mode = 1; in_valid = 4'hF; out_ready = 1;
    cyc();
    out_ready = 0;
    cyc();
    #3;
    rst_n = 0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_xfer_cnt", 32'(xfer_cnt), 0);
    chk("async_in_ready", 32'(in_ready), 0);
    in_valid = 4'h0;
    @(posedge clk); #4;
    rst_n = 1;
    @(posedge clk); #1;
    model_reset();
    in_valid = 4'hF; out_ready = 1;
    cyc();
    chk("post_rst_ch", 32'(out_ch), 0);
    in_valid = 4'h0;
    // 3-channel build: out-of-range select never grants
    sel3 = 2'd3; iv3 = 3'b111; ordy3 = 1;
    repeat (4) begin
      #2;
      chk("oor_ready", 32'(rdy3), 0);
      @(posedge clk); #1;
      chk("oor_valid", 32'(ov3), 0);
      chk("oor_cnt", 32'(cnt3), 0);
    end
    sel3 = 2'd1;
    #2;
    chk("sel1_ready", 32'(rdy3), 32'b010);
    @(posedge clk); #1;
    chk("sel1_data", 32'(od3), 32'hB1);
    chk("sel1_ch", 32'(oc3), 1);
    sel3 = 2'd3; ordy3 = 0;
    @(posedge clk); #1;
    chk("held_valid", 32'(ov3), 1);
    ordy3 = 1;
    #2;
    chk("drain_ready", 32'(rdy3), 0);
    @(posedge clk); #1;
    chk("drain_valid", 32'(ov3), 0);
    chk("drain_cnt", 32'(cnt3), 1);
    // counter wrap on a 4-bit counter: transfers 2..17
    mode3 = 1;
    for (int k = 2; k <= 17; k++) begin
      @(posedge clk); #1;
      chk("wrap_cnt", 32'(cnt3), k % 16);
      chk("wrap_ch", 32'(oc3), (k - 2) % 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
